// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/WB control sequencer for the datapath.
// It drives every datapath enable and select, detects halt, illegal-opcode
// and fetch-timeout conditions, and counts retired instructions.
module multicycle_ctrl #(
  parameter int EXEC_CYCLES   = 1,
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       instr_op_i,
  input  logic [5:0]       funct_i,
  input  logic             imem_ack_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             alu_src_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       result_sel_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Terminal values: EXEC runs from EXEC_LAST down to 0, FETCH gives up on
  // the cycle where the no-ack count has already reached TO_LAST.
  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(FETCH_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic [3:0]       exec_cnt_q, exec_cnt_d;
  logic             imem_req_q, imem_req_d;
  logic             reg_write_q, reg_write_d;
  logic             pc_we_q, pc_we_d;
  logic             reg_dst_q, reg_dst_d;
  logic             alu_src_q, alu_src_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [1:0]       result_sel_q, result_sel_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Next state, counters and decoded selects; Moore outputs follow state_d so
  // they appear registered in the cycle the state is entered.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    exec_cnt_d   = exec_cnt_q;
    reg_dst_d    = reg_dst_q;
    alu_src_d    = alu_src_q;
    alu_op_d     = alu_op_q;
    result_sel_d = result_sel_q;
    err_d        = err_q;
    instr_cnt_d  = instr_cnt_q;
    ir_we_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_FETCH;
          to_cnt_d = 8'd0;
        end
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          ir_we_o = ~rst_i;
          state_d = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d    = S_EXEC;
        exec_cnt_d = EXEC_LAST;
        case (instr_op_i)
          OP_RTYPE: begin
            reg_dst_d    = 1'b1;
            alu_src_d    = 1'b0;
            alu_op_d     = 3'b010;
            result_sel_d = (funct_i inside {6'b000000, 6'b000010, 6'b000100, 6'b000110})
                           ? 2'd1 : 2'd0;
          end
          OP_ADDI: begin
            reg_dst_d    = 1'b0;
            alu_src_d    = 1'b1;
            alu_op_d     = 3'b011;
            result_sel_d = 2'd0;
          end
          OP_LUI: begin
            reg_dst_d    = 1'b0;
            alu_src_d    = 1'b1;
            alu_op_d     = 3'b100;
            result_sel_d = 2'd2;
          end
          OP_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (exec_cnt_q == 4'd0) begin
          state_d = S_WB;
        end else begin
          exec_cnt_d = exec_cnt_q - 4'd1;
        end
      end
      S_WB: begin
        state_d      = S_FETCH;
        to_cnt_d     = 8'd0;
        reg_dst_d    = 1'b0;
        alu_src_d    = 1'b0;
        alu_op_d     = 3'b000;
        result_sel_d = 2'd0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    imem_req_d  = (state_d == S_FETCH);
    reg_write_d = (state_d == S_WB);
    pc_we_d     = (state_d == S_WB);
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d    = (state_d == S_HALT);

    // The count is updated as WB is entered; WB lasts one cycle, so each
    // retired instruction adds exactly one, holding at all-ones.
    if ((state_d == S_WB) && (instr_cnt_q != {CNT_W{1'b1}})) begin
      instr_cnt_d = instr_cnt_q + 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values of the others, independent of statement order.
    if (rst_i) begin
      state_q      <= S_IDLE;
      to_cnt_q     <= 8'd0;
      exec_cnt_q   <= 4'd0;
      imem_req_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_we_q      <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 3'b000;
      result_sel_q <= 2'd0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
      instr_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      exec_cnt_q   <= exec_cnt_d;
      imem_req_q   <= imem_req_d;
      reg_write_q  <= reg_write_d;
      pc_we_q      <= pc_we_d;
      reg_dst_q    <= reg_dst_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      result_sel_q <= result_sel_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign imem_req_o   = imem_req_q;
  assign pc_we_o      = pc_we_q;
  assign reg_write_o  = reg_write_q;
  assign reg_dst_o    = reg_dst_q;
  assign alu_src_o    = alu_src_q;
  assign alu_op_o     = alu_op_q;
  assign result_sel_o = result_sel_q;
  assign busy_o       = busy_q;
  assign halted_o     = halted_q;
  assign err_o        = err_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream against a reference model.
// The stimulus process pushes the expected WB/HALT events into a scoreboard
// queue; a monitor on the falling edge pops and compares them.
// A second instance (EXEC_CYCLES=4, CNT_W=2, FETCH_TIMEOUT=4) covers counter
// saturation, reset during EXEC and the timeout boundary.
module tb_multicycle_ctrl;

  localparam int E1  = 1;
  localparam int TO1 = 16;
  localparam int E2  = 4;
  localparam int TO2 = 4;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 (default parameters)
  logic        rst, start, ack;
  logic [5:0]  op, funct;
  logic        imem_req, ir_we, pc_we, reg_write, reg_dst, alu_src, busy, halted, err;
  logic [2:0]  alu_op;
  logic [1:0]  result_sel;
  logic [15:0] icnt;

  // Instance 2
  logic        rst2, start2, ack2;
  logic [5:0]  op2, funct2;
  logic        imem_req2, ir_we2, pc_we2, reg_write2, reg_dst2, alu_src2, busy2, halted2, err2;
  logic [2:0]  alu_op2;
  logic [1:0]  result_sel2;
  logic [CW2-1:0] icnt2;

  multicycle_ctrl #(.EXEC_CYCLES(E1), .FETCH_TIMEOUT(TO1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .instr_op_i(op), .funct_i(funct),
    .imem_ack_i(ack), .imem_req_o(imem_req), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .alu_src_o(alu_src),
    .alu_op_o(alu_op), .result_sel_o(result_sel), .busy_o(busy),
    .halted_o(halted), .err_o(err), .instr_cnt_o(icnt)
  );

  multicycle_ctrl #(.EXEC_CYCLES(E2), .FETCH_TIMEOUT(TO2), .CNT_W(CW2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .instr_op_i(op2), .funct_i(funct2),
    .imem_ack_i(ack2), .imem_req_o(imem_req2), .ir_we_o(ir_we2), .pc_we_o(pc_we2),
    .reg_write_o(reg_write2), .reg_dst_o(reg_dst2), .alu_src_o(alu_src2),
    .alu_op_o(alu_op2), .result_sel_o(result_sel2), .busy_o(busy2),
    .halted_o(halted2), .err_o(err2), .instr_cnt_o(icnt2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_LEGAL, K_HALT, K_ILL} kind_t;

  typedef struct {
    bit       is_halt;
    int       cyc;
    bit       reg_dst;
    bit       alu_src;
    bit [2:0] alu_op;
    bit [1:0] rsel;
    bit       err;
    int       cnt;
  } exp_t;

  exp_t q[$];
  int   m_cnt     = 0;
  bit   m_err     = 0;
  int   nxt_fetch = 0;

  function automatic kind_t ref_kind(input logic [5:0] o);
    if (o == 6'd0 || o == 6'b001000 || o == 6'b001111) return K_LEGAL;
    if (o == 6'b111111) return K_HALT;
    return K_ILL;
  endfunction

  function automatic exp_t ref_sel(input logic [5:0] o, input logic [5:0] f);
    exp_t e;
    e = '{default: 0};
    if (o == 6'd0) begin
      e.reg_dst = 1; e.alu_src = 0; e.alu_op = 3'd2;
      e.rsel = (f == 6'd0 || f == 6'd2 || f == 6'd4 || f == 6'd6) ? 2'd1 : 2'd0;
    end else if (o == 6'b001000) begin
      e.reg_dst = 0; e.alu_src = 1; e.alu_op = 3'd3; e.rsel = 2'd0;
    end else begin
      e.reg_dst = 0; e.alu_src = 1; e.alu_op = 3'd4; e.rsel = 2'd2;
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit mon_en      = 0;
  bit halted_seen = 0;
  bit pend        = 0;
  int pend_cnt    = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && !rst) begin
      check("ir_we_rule", ir_we, imem_req && ack);
      check("pc_we_eq_reg_write", pc_we, reg_write);
      if (pend) begin
        check("instr_cnt_after_wb", icnt, pend_cnt);
        check("selects_cleared", {reg_dst, alu_src, alu_op, result_sel}, 0);
        check("single_wb_pulse", reg_write, 0);
      end
      pend <= 0;
      if (reg_write || (halted && !halted_seen)) begin
        if (q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          check("event_kind_halt", halted, e.is_halt);
          check("event_cycle", cyc, e.cyc);
          if (e.is_halt) begin
            check("halt_err", err, e.err);
            check("halt_cnt", icnt, e.cnt);
            check("halt_busy", busy, 0);
            check("halt_req", imem_req, 0);
          end else begin
            check("wb_reg_dst", reg_dst, e.reg_dst);
            check("wb_alu_src", alu_src, e.alu_src);
            check("wb_alu_op", alu_op, e.alu_op);
            check("wb_result_sel", result_sel, e.rsel);
            check("wb_busy", busy, 1);
            pend     <= 1;
            pend_cnt <= e.cnt;
          end
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        check("event_missed_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
    halted_seen <= halted;
  end

  int wb2_pulses = 0;
  always @(negedge clk) if (reg_write2 === 1'b1) wb2_pulses <= wb2_pulses + 1;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; start = 1; ack = 1;
    #1 check("ir_we_during_reset", ir_we, 0);
    tick();
    rst = 0; start = 0; ack = 0;
    m_cnt = 0; m_err = 0;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_req", imem_req, 0);
    check("rst_cnt", icnt, 0);
    check("rst_enables", {reg_write, pc_we, reg_dst, alu_src, alu_op, result_sel}, 0);
  endtask

  task automatic start_run();
    start = 1;
    nxt_fetch = cyc + 1;
    tick();
    start = 0;
  endtask

  task automatic wait_fetch(output int tf);
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      ack = 1'($urandom);  // must be ignored outside FETCH
      tick();
      n++;
    end
    ack = 0;
    if (!imem_req) check("fetch_wait_expired", 0, 1);
    tf = cyc;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input int d);
    int   tf, t;
    exp_t e;
    wait_fetch(tf);
    check("fetch_start_cycle", tf, nxt_fetch);
    repeat (d) tick();
    ack = 1; op = o; funct = f;
    t = cyc;
    case (ref_kind(o))
      K_LEGAL: begin
        e = ref_sel(o, f);
        if (m_cnt < 65535) m_cnt++;
        e.is_halt = 0; e.cyc = t + 2 + E1; e.cnt = m_cnt;
        nxt_fetch = t + 3 + E1;
      end
      K_HALT: begin
        e = '{default: 0};
        e.is_halt = 1; e.cyc = t + 2; e.err = m_err; e.cnt = m_cnt;
      end
      default: begin
        m_err = 1;
        e = '{default: 0};
        e.is_halt = 1; e.cyc = t + 2; e.err = 1; e.cnt = m_cnt;
      end
    endcase
    q.push_back(e);
    tick();
    ack = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    check("scoreboard_drained", q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int tf, t, n, k;
    logic [5:0] ro, rf;
    exp_t e;
    rst = 0; start = 0; ack = 0; op = 0; funct = 0;
    rst2 = 0; start2 = 0; ack2 = 0; op2 = 0; funct2 = 0;
    repeat (2) tick();

    // Instance 1: directed then randomized legal stream
    do_reset();
    mon_en = 1;
    tick();
    check("idle_holds_without_start", busy, 0);
    start_run();
    issue(6'b001000, 6'd0, 0);   // addi
    issue(6'b000000, 6'd2, 0);   // srl
    issue(6'b001111, 6'd0, 0);   // lui
    issue(6'b001000, 6'd0, 3);   // ack delayed by three cycles
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      ro = (k == 0) ? 6'b000000 : (k == 1) ? 6'b001000 : 6'b001111;
      rf = ($urandom_range(0, 1) == 0) ? 6'(2 * $urandom_range(0, 3)) : 6'($urandom);
      issue(ro, rf, $urandom_range(0, 3));
    end
    issue(6'b111111, 6'd0, 1);   // halt: err stays 0, count unchanged
    drain();
    start = 1; repeat (3) tick(); start = 0;
    check("halt_ignores_start", halted, 1);
    check("halt_no_req", imem_req, 0);

    // Illegal opcode
    do_reset();
    start_run();
    issue(6'b001000, 6'd0, 0);
    issue(6'b010101, 6'd0, 2);
    drain();

    // Fetch timeout
    do_reset();
    start_run();
    wait_fetch(tf);
    e = '{default: 0};
    e.is_halt = 1; e.cyc = tf + TO1; e.err = 1; e.cnt = 0;
    q.push_back(e);
    repeat (TO1 + 2) tick();
    drain();
    start = 1; repeat (3) tick(); start = 0;
    check("timeout_halted_after_start", halted, 1);
    check("timeout_err_sticky", err, 1);
    check("timeout_busy", busy, 0);

    // Instance 2: latency, saturation, reset in EXEC, timeout boundary
    rst2 = 1; tick(); rst2 = 0;
    check("d2_rst_cnt", icnt2, 0);
    start2 = 1; tick(); start2 = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!imem_req2 && n < 20) begin tick(); n++; end
      check("d2_fetch_seen", imem_req2, 1);
      ack2 = 1; op2 = 6'b001000; funct2 = 6'd0;
      t = cyc;
      tick();
      ack2 = 0;
      n = 0;
      while (!reg_write2 && n < 20) begin tick(); n++; end
      check("d2_wb_cycle", cyc, t + 2 + E2);
      tick();
      check("d2_cnt_saturating", icnt2, (i + 1 > 3) ? 3 : i + 1);
    end
    // now in FETCH of the sixth instruction
    ack2 = 1; tick(); ack2 = 0;           // DECODE
    tick(); tick();                       // EXEC, EXEC
    check("d2_busy_in_exec", busy2, 1);
    rst2 = 1; tick(); rst2 = 0;
    check("d2_abort_busy", busy2, 0);
    check("d2_abort_outputs",
          {imem_req2, reg_write2, pc_we2, reg_dst2, alu_src2, alu_op2, result_sel2, halted2, err2}, 0);
    check("d2_abort_cnt", icnt2, 0);
    repeat (6) tick();
    check("d2_no_wb_after_abort", wb2_pulses, 5);
    check("d2_idle_after_abort", busy2, 0);

    start2 = 1; tick(); start2 = 0;
    check("d2_to_fetch", imem_req2, 1);
    repeat (TO2 - 1) tick();
    check("d2_to_last_fetch_req", imem_req2, 1);
    check("d2_to_not_yet_halted", halted2, 0);
    tick();
    check("d2_to_halted", halted2, 1);
    check("d2_to_err", err2, 1);
    check("d2_to_req_dropped", imem_req2, 0);
    start2 = 1; repeat (2) tick(); start2 = 0;
    check("d2_halt_ignores_start", {halted2, busy2}, 2'b10);
    check("d2_no_wb_in_timeout", wb2_pulses, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the single-cycle datapath (PC, instruction memory, register file, ALU, shifter, result mux).
- Steps each instruction through FETCH/DECODE/EXEC/WB, so the ALU path may take several cycles and instruction memory may answer with a variable latency.
- Replaces the combinational decoder/ALU-control pairing as the source of all datapath enables and selects.
- Adds halt, illegal-opcode and fetch-timeout detection, plus a retired-instruction counter.

Parameters:
- EXEC_CYCLES, 1, cycles spent in EXEC per instruction (1..15).
- FETCH_TIMEOUT, 16, FETCH cycles without imem_ack_i before error (2..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  leave IDLE and begin fetching.
- instr_op_i  in  6  opcode field, instr[31:26], of the current IR.
- funct_i  in  6  funct field, instr[5:0], of the current IR.
- imem_ack_i  in  1  instruction memory data valid this cycle.
- imem_req_o  out  1  fetch request to instruction memory.
- ir_we_o  out  1  latch instruction register.
- pc_we_o  out  1  PC <= PC+4 enable.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  1  0 = rt, 1 = rd.
- alu_src_o  out  1  0 = RT data, 1 = sign-extended immediate.
- alu_op_o  out  3  ALUOp to ALU control.
- result_sel_o  out  2  0 = ALU, 1 = shifter, 2 = zero-filled immediate.
- busy_o  out  1  state not IDLE and not HALT.
- halted_o  out  1  in HALT.
- err_o  out  1  sticky error flag.
- instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset, when rst_i is high at a clock edge:
  - State becomes IDLE; all outputs 0; instr_cnt_o 0; err_o 0; internal counters 0.
  - rst_i overrides every other input in the same cycle.
  - Reset mid-instruction aborts the instruction with no WB pulse.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. All outputs are registered/Moore except ir_we_o.
- IDLE: all enables 0. start_i=1 -> FETCH.
- FETCH:
  - imem_req_o=1.
  - ir_we_o = imem_ack_i, combinational, same cycle.
  - Ack -> DECODE.
  - No ack: the timeout counter increments. On the FETCH_TIMEOUT-th cycle without ack -> HALT with err_o=1.
  - The timeout counter clears on entry to FETCH.
- DECODE (one cycle): decode fields and latch them into the control output registers.
  - op 000000 (R-type): reg_dst=1, alu_src=0, alu_op=010.
    - funct 000000/000010/000100/000110 (sll/srl/sllv/srlv): result_sel=1.
    - Any other funct: result_sel=0.
  - op 001000 (addi): reg_dst=0, alu_src=1, alu_op=011, result_sel=0.
  - op 001111 (lui): reg_dst=0, alu_src=1, alu_op=100, result_sel=2.
  - op 111111 (halt) -> HALT, err_o unchanged, pc_we never pulsed.
  - Any other op -> HALT with err_o=1.
  - Legal, non-halt op -> EXEC; exec counter loads EXEC_CYCLES-1.
- EXEC:
  - reg_dst/alu_src/alu_op/result_sel are held stable from the DECODE edge through the last WB cycle.
  - Counter decrements each cycle; counter=0 -> WB.
- WB (exactly one cycle):
  - reg_write_o=1 and pc_we_o=1.
  - instr_cnt_o increments, saturating at all-ones.
  - Next state FETCH.
  - Selects return to 0 on leaving WB.
- HALT: halted_o=1; all enables 0; start_i ignored; exit only via rst_i.
- err_o is sticky until reset.
- Latency: with ack in the first FETCH cycle, one instruction takes 3+EXEC_CYCLES cycles (4 at default). Each cycle of ack delay adds one cycle.
- imem_ack_i outside FETCH is ignored.
- Only one reg_write_o/pc_we_o pulse per retired instruction.

Test Plan:
- Reset, start_i=1, ack on first FETCH cycle, op=001000, EXEC_CYCLES=1 -> states FETCH,DECODE,EXEC,WB; reg_write_o=pc_we_o=1 only in cycle 4; alu_src_o=1, alu_op_o=011; instr_cnt_o=1.
- R-type funct=000010 followed by lui, back-to-back -> result_sel_o=1 then 2; reg_dst_o=1 then 0; instr_cnt_o=2 after 8 cycles.
- Ack delayed 3 cycles -> imem_req_o high 4 cycles; ir_we_o high only in the ack cycle; WB 3 cycles later than the zero-delay case.
- No ack for 16 FETCH cycles (FETCH_TIMEOUT=16) -> HALT; err_o=1; halted_o=1; pc_we_o never pulsed; start_i ignored afterwards.
- op=111111 -> HALT with err_o=0 and instr_cnt_o unchanged. op=010101 -> HALT with err_o=1.
- rst_i asserted during EXEC with EXEC_CYCLES=4 -> next cycle IDLE, all outputs 0, no WB pulse. Run with CNT_W=2 and 5 instructions -> instr_cnt_o saturates at 3.
